// File: rtl/counter_pkg.sv
// Shared definitions for the flexible sample counter.
//   DEFAULT_NUM_BITS  : default width of the count word and rollover value
//   SAMPLES_PER_BLOCK : block length of the legacy fixed-size counter
//   count_t           : count word at the default width
package counter_pkg;

    localparam int DEFAULT_NUM_BITS = 10;
    localparam logic [9:0] SAMPLES_PER_BLOCK = 10'd1000;

    typedef logic [DEFAULT_NUM_BITS-1:0] count_t;

endpackage

// File: rtl/flex_sample_counter_if.sv
// Bus bundle between the sample-ready logic (master) and the counter (slave).
//   clear, count_enable, rollover_val : master -> counter controls
//   count_out, rollover_flag,
//   wrap_pulse, wrap_total            : counter -> master status
interface flex_sample_counter_if
    import counter_pkg::*;
#(
    parameter int NUM_BITS  = DEFAULT_NUM_BITS,
    parameter int WRAP_BITS = 8
);

    logic                 clear;
    logic                 count_enable;
    logic [NUM_BITS-1:0]  rollover_val;
    logic [NUM_BITS-1:0]  count_out;
    logic                 rollover_flag;
    logic                 wrap_pulse;
    logic [WRAP_BITS-1:0] wrap_total;

    modport master (
        output clear, count_enable, rollover_val,
        input  count_out, rollover_flag, wrap_pulse, wrap_total
    );

    modport slave (
        input  clear, count_enable, rollover_val,
        output count_out, rollover_flag, wrap_pulse, wrap_total
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating incrementer with synchronous clear.
//   clk     : system clock, rising edge
//   n_reset : synchronous active-low reset, forces count to 0
//   clear   : synchronous clear, beats inc
//   inc     : add one unless already all-ones
//   count   : registered count value
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/flex_sample_counter.sv
// Counts enabled sample strobes up to a programmable rollover value and
// flags each completed block.
//   clk     : system clock, rising edge
//   n_reset : synchronous active-low reset
//   bus     : slave side of flex_sample_counter_if
//             clear / count_enable / rollover_val in,
//             count_out / rollover_flag / wrap_pulse / wrap_total out
// Parameters: NUM_BITS (count width), WRAP_BITS (block tally width),
//             SATURATE (0 = wrap to 1 at rollover, 1 = hold at rollover).
module flex_sample_counter
    import counter_pkg::*;
#(
    parameter int NUM_BITS  = DEFAULT_NUM_BITS,
    parameter int WRAP_BITS = 8,
    parameter bit SATURATE  = 1'b0
) (
    input  logic                   clk,
    input  logic                   n_reset,
    flex_sample_counter_if.slave   bus
);

    logic [NUM_BITS-1:0] count_q;
    logic [NUM_BITS-1:0] count_d;
    logic                flag_q;
    logic                flag_d;
    logic                pulse_q;
    logic                pulse_d;
    logic                wrap_inc;
    logic                term;

    // ">=" rather than "==" so that lowering rollover_val below the
    // current count still ends the block on the next strobe.
    assign term = (count_q >= bus.rollover_val);

    always_comb begin
        count_d  = count_q;
        flag_d   = flag_q;
        pulse_d  = 1'b0;
        wrap_inc = 1'b0;
        if (bus.clear) begin
            count_d = '0;
            flag_d  = 1'b0;
        end else begin
            if (bus.count_enable) begin
                if (bus.rollover_val == '0) begin
                    // Disabled mode: pinned at zero, never wraps.
                    count_d = '0;
                end else if (!term) begin
                    count_d = count_q + NUM_BITS'(1);
                end else if (!SATURATE) begin
                    // Wrap lands on 1 so every later block is also N strobes.
                    count_d  = NUM_BITS'(1);
                    pulse_d  = 1'b1;
                    wrap_inc = 1'b1;
                end
            end
            // Flag tracks the value being loaded, so it lines up with count_out.
            flag_d = (count_d == bus.rollover_val);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            count_q <= '0;
            flag_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
            pulse_q <= pulse_d;
        end
    end

    sat_counter #(
        .WIDTH (WRAP_BITS)
    ) u_wrap_total (
        .clk     (clk),
        .n_reset (n_reset),
        .clear   (bus.clear),
        .inc     (wrap_inc),
        .count   (bus.wrap_total)
    );

    assign bus.count_out     = count_q;
    assign bus.rollover_flag = flag_q;
    assign bus.wrap_pulse    = pulse_q;

endmodule

// File: tb/tb_flex_sample_counter.sv
// Directed bench for flex_sample_counter: wrap build (8-bit tally),
// saturate build, and wrap build with a 2-bit tally.
module tb_flex_sample_counter;
    import counter_pkg::*;

    logic clk;
    logic n_reset;
    int   tests;
    int   fails;

    flex_sample_counter_if #(.NUM_BITS(10), .WRAP_BITS(8)) bus_w ();
    flex_sample_counter_if #(.NUM_BITS(10), .WRAP_BITS(8)) bus_s ();
    flex_sample_counter_if #(.NUM_BITS(10), .WRAP_BITS(2)) bus_t ();

    flex_sample_counter #(.NUM_BITS(10), .WRAP_BITS(8), .SATURATE(1'b0)) dut_wrap (
        .clk (clk), .n_reset (n_reset), .bus (bus_w.slave)
    );
    flex_sample_counter #(.NUM_BITS(10), .WRAP_BITS(8), .SATURATE(1'b1)) dut_sat (
        .clk (clk), .n_reset (n_reset), .bus (bus_s.slave)
    );
    flex_sample_counter #(.NUM_BITS(10), .WRAP_BITS(2), .SATURATE(1'b0)) dut_w2 (
        .clk (clk), .n_reset (n_reset), .bus (bus_t.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int exp3_cnt  [10] = '{1, 1, 2, 2, 3, 3, 4, 4, 1, 1};
    int exp3_flag [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
    int exp3_pulse[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    initial begin
        tests = 0;
        fails = 0;

        // 1. Reset with enable high
        n_reset = 1'b0;
        bus_w.clear = 1'b0; bus_w.count_enable = 1'b1; bus_w.rollover_val = 10'd5;
        bus_s.clear = 1'b0; bus_s.count_enable = 1'b1; bus_s.rollover_val = 10'd5;
        bus_t.clear = 1'b0; bus_t.count_enable = 1'b1; bus_t.rollover_val = 10'd5;
        tick();
        tick();
        check("rst_count", 32'(bus_w.count_out), 0);
        check("rst_flag",  32'(bus_w.rollover_flag), 0);
        check("rst_pulse", 32'(bus_w.wrap_pulse), 0);
        check("rst_total", 32'(bus_w.wrap_total), 0);
        check("rst_sat_count", 32'(bus_s.count_out), 0);
        check("rst_w2_total",  32'(bus_t.wrap_total), 0);
        bus_s.count_enable = 1'b0;
        bus_t.count_enable = 1'b0;
        $display("[TB] reset done");

        // 2. Basic wrap at 1000, enable held for 2000 edges
        bus_w.rollover_val = SAMPLES_PER_BLOCK;
        bus_w.count_enable = 1'b1;
        n_reset = 1'b1;
        for (int k = 1; k <= 2000; k++) begin
            tick();
            check("blk_count", 32'(bus_w.count_out), (k <= 1000) ? k : k - 1000);
            check("blk_flag",  32'(bus_w.rollover_flag), (k == 1000 || k == 2000) ? 1 : 0);
            check("blk_pulse", 32'(bus_w.wrap_pulse), (k == 1001) ? 1 : 0);
            if (k == 1001) check("blk_total_1001", 32'(bus_w.wrap_total), 1);
        end
        check("blk_total_end", 32'(bus_w.wrap_total), 1);
        $display("[TB] 2000-strobe wrap test: count=%0d total=%0d", bus_w.count_out, bus_w.wrap_total);

        // 3. Gated enable, rollover 4
        bus_w.count_enable = 1'b0;
        bus_w.clear = 1'b1;
        tick();
        check("g_clr_count", 32'(bus_w.count_out), 0);
        bus_w.clear = 1'b0;
        bus_w.rollover_val = 10'd4;
        for (int i = 0; i < 10; i++) begin
            bus_w.count_enable = (i % 2 == 0);
            tick();
            check("g_count", 32'(bus_w.count_out), exp3_cnt[i]);
            check("g_flag",  32'(bus_w.rollover_flag), exp3_flag[i]);
            check("g_pulse", 32'(bus_w.wrap_pulse), exp3_pulse[i]);
        end
        check("g_total", 32'(bus_w.wrap_total), 1);
        $display("[TB] gated enable: count=%0d total=%0d", bus_w.count_out, bus_w.wrap_total);

        // 4. Clear beats count_enable, rollover 10
        bus_w.clear = 1'b1;
        bus_w.count_enable = 1'b0;
        tick();
        bus_w.clear = 1'b0;
        bus_w.rollover_val = 10'd10;
        bus_w.count_enable = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("c_pre_count", 32'(bus_w.count_out), 7);
        bus_w.clear = 1'b1;
        tick();
        check("c_count", 32'(bus_w.count_out), 0);
        check("c_flag",  32'(bus_w.rollover_flag), 0);
        check("c_total", 32'(bus_w.wrap_total), 0);
        bus_w.clear = 1'b0;
        tick();
        check("c_resume1", 32'(bus_w.count_out), 1);
        tick();
        check("c_resume2", 32'(bus_w.count_out), 2);
        $display("[TB] clear priority: count=%0d", bus_w.count_out);

        // 5. Saturate build, rollover 3, 10 enabled edges
        bus_s.rollover_val = 10'd3;
        bus_s.count_enable = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("s_count", 32'(bus_s.count_out), (k < 3) ? k : 3);
            check("s_flag",  32'(bus_s.rollover_flag), (k >= 3) ? 1 : 0);
            check("s_pulse", 32'(bus_s.wrap_pulse), 0);
        end
        check("s_total", 32'(bus_s.wrap_total), 0);
        bus_s.count_enable = 1'b0;
        $display("[TB] saturate: count=%0d total=%0d", bus_s.count_out, bus_s.wrap_total);

        // 6a. Lower rollover mid-count
        bus_w.count_enable = 1'b0;
        bus_w.clear = 1'b1;
        tick();
        bus_w.clear = 1'b0;
        bus_w.rollover_val = 10'd10;
        bus_w.count_enable = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("r_pre_count", 32'(bus_w.count_out), 8);
        bus_w.rollover_val = 10'd5;
        tick();
        check("r_low_count", 32'(bus_w.count_out), 1);
        check("r_low_pulse", 32'(bus_w.wrap_pulse), 1);
        check("r_low_total", 32'(bus_w.wrap_total), 1);

        // 6b. Disabled mode
        bus_w.rollover_val = 10'd0;
        tick();
        check("z_count", 32'(bus_w.count_out), 0);
        check("z_flag",  32'(bus_w.rollover_flag), 1);
        check("z_pulse", 32'(bus_w.wrap_pulse), 0);
        tick();
        check("z_hold_count", 32'(bus_w.count_out), 0);
        check("z_hold_flag",  32'(bus_w.rollover_flag), 1);
        check("z_hold_pulse", 32'(bus_w.wrap_pulse), 0);
        check("z_total", 32'(bus_w.wrap_total), 1);
        bus_w.count_enable = 1'b0;
        $display("[TB] rollover change: count=%0d flag=%0d", bus_w.count_out, bus_w.rollover_flag);

        // 6c. Two-bit block tally saturates; rollover 2 wraps on edges 3,5,7,9,11
        bus_t.rollover_val = 10'd2;
        bus_t.count_enable = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 5)  check("t_total_5",  32'(bus_t.wrap_total), 2);
            if (k == 7)  check("t_total_7",  32'(bus_t.wrap_total), 3);
            if (k == 11) check("t_total_11", 32'(bus_t.wrap_total), 3);
        end
        check("t_count", 32'(bus_t.count_out), 1);
        check("t_pulse", 32'(bus_t.wrap_pulse), 1);
        bus_t.count_enable = 1'b0;
        $display("[TB] 2-bit tally: total=%0d", bus_t.wrap_total);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/flex_sample_counter.md
Name: flex_sample_counter

Overview:
Parametrised successor to the fixed 1000-sample counter. It counts enabled sample strobes up to a run-time programmable rollover value and flags each completed block of N samples. It supports wrap or saturate mode, synchronous clear, and a saturating count of completed blocks. It sits between the sample-ready logic and the block-level controller or FIR sequencer.

Parameters:
NUM_BITS, 10, width of count_out and rollover_val
WRAP_BITS, 8, width of wrap_total
SATURATE, 0, 0 means wrap at rollover; 1 means hold at rollover_val until clear

Ports:
clk  input  1  system clock, rising edge
n_reset  input  1  synchronous active-low reset
clear  input  1  synchronous clear, higher priority than count_enable
count_enable  input  1  one increment per cycle while high
rollover_val  input  NUM_BITS  terminal count N; sampled every cycle
count_out  output  NUM_BITS  current count
rollover_flag  output  1  high while count_out == rollover_val (registered)
wrap_pulse  output  1  one-cycle pulse in the cycle after count_out wraps
wrap_total  output  WRAP_BITS  number of completed blocks, saturating at all-ones

Behaviour:
- One clock domain. Reset is synchronous and active-low: n_reset low at a rising clk edge forces count_out=0, rollover_flag=0, wrap_pulse=0, wrap_total=0. The reset condition has the highest priority.
- Priority per edge: n_reset, then clear, then count_enable, then hold.
- clear=1: same values as reset. wrap_total is also zeroed.
- Terminal condition T is count_out >= rollover_val. Using >= covers rollover_val being lowered mid-count.
- count_enable=1, not T: count_out <= count_out+1.
- count_enable=1, T, SATURATE=0: count_out <= 1 (wrap). wrap_pulse <= 1 for exactly that edge. wrap_total <= wrap_total+1 unless it is all-ones.
- count_enable=1, T, SATURATE=1: count_out holds. No pulse. wrap_total is unchanged.
- count_enable=0: all state holds. wrap_pulse <= 0.
- With wrap to 1, rollover_flag asserts on every Nth enabled strobe. The first block after reset takes N strobes (0 to N). Later blocks also take N strobes (1 to N).
- rollover_flag is registered and updated in the same edge as count_out. It always equals (next count_out == rollover_val). Zero latency relative to count_out.
- rollover_val=0: T is always true. The counter is forced to 0 and held there; no increment, no pulses, flag=1 (0==0). Define this as the "disabled" mode.
- rollover_val=1 with SATURATE=0: count_out stays at 1 after the first strobe. rollover_flag stays high and wrap_pulse fires on every enabled cycle after the first.
- count_out never exceeds max(rollover_val, previous count_out). There is no arithmetic overflow because the NUM_BITS all-ones value is always >= rollover_val.
- Reset or clear asserted mid-block discards the partial count with no pulse.
- A clear in the same cycle as a wrap suppresses the wrap: no pulse, and wrap_total becomes 0.
- All outputs come directly from flops. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package counter_pkg:
  - localparam DEFAULT_NUM_BITS=10.
  - localparam SAMPLES_PER_BLOCK=10'd1000.
  - A typedef for the count word.
- One natural sub-module: sat_counter, a WRAP_BITS saturating incrementer with clear. It is used for wrap_total.
- The main count and flag logic stays in flex_sample_counter. It is split into a next-state combinational block and a single registered block.

Test Plan:
1. Reset: drive n_reset=0 for 2 edges with count_enable=1 and rollover_val=5 -> count_out=0, rollover_flag=0, wrap_pulse=0, wrap_total=0.
2. Basic wrap, SATURATE=0, rollover_val=1000, enable held 2000 cycles:
   - flag is high after edges 1000 and 2000 only.
   - count_out is 1 after edge 1001.
   - wrap_pulse is high for exactly the one cycle following edge 1001.
   - wrap_total=1 after edge 1001.
3. Gated enable, rollover_val=4, enable toggling 1,0,1,0,...:
   - count_out advances only on enabled edges.
   - flag is high after the 4th enabled edge and stays high while enable=0.
   - the next enabled edge wraps to 1 with a pulse.
4. Clear priority, rollover_val=10: drive count to 7, then assert clear and count_enable together -> count_out=0, flag=0, wrap_total=0. The counter resumes 1,2,... after clear drops.
5. Saturate build (SATURATE=1), rollover_val=3, enable held 10 cycles -> count_out sticks at 3, flag stays 1, wrap_pulse never asserts, wrap_total=0.
6. Rollover changes, SATURATE=0:
   - count to 8 with rollover_val=10, then set rollover_val=5 -> the next enabled edge gives count_out=1 with a pulse.
   - set rollover_val=0 -> count_out=0 and held, flag=1.
   - saturation: with WRAP_BITS=2 and 5 wraps, wrap_total=3.
